// File: rtl/aix_quant_pkg.sv
// Shared widths, FSM encoding and saturation bounds for the psum requantiser.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package aix_quant_pkg;

  // Default widths. The top-level parameters take these values.
  localparam int WA_DEF = 26;  // MAC partial-sum width
  localparam int WS_DEF = 32;  // internal accumulator width
  localparam int WB_DEF = 16;  // bias width
  localparam int WT_DEF = 8;   // tile-count width
  localparam int WQ_DEF = 8;   // output activation width

  typedef enum logic {
    ST_IDLE  = 1'b0,
    ST_ACCUM = 1'b1
  } state_t;

  localparam logic signed [WQ_DEF-1:0] SAT_MAX = {1'b0, {(WQ_DEF-1){1'b1}}};
  localparam logic signed [WQ_DEF-1:0] SAT_MIN = {1'b1, {(WQ_DEF-1){1'b0}}};

  // Sign-extend the low w bits of v to the full accumulator width.
  function automatic logic [WS_DEF-1:0] sext(input logic [WS_DEF-1:0] v,
                                             input int unsigned w);
    logic [WS_DEF-1:0] hi_mask;
    logic [WS_DEF-1:0] tmp;
    hi_mask = {WS_DEF{1'b1}} << w;
    tmp     = v >> (w - 1);
    return tmp[0] ? (v | hi_mask) : (v & ~hi_mask);
  endfunction

endpackage

// File: rtl/requant_rs.sv
// Round, arithmetic-shift, then saturate (and optionally ReLU) a finished partial sum.
// Latency: 2 cycles from in_vld to vld_o.
// Backpressure: none; every in_vld produces a vld_o two cycles later.
//
// Ports:
//   clk, rstn        clock, async active-low reset
//   in_vld/in_dat    finished accumulator value and its strobe
//   in_ovf           accumulator overflowed during this group (forces sat_o)
//   in_shift/in_relu config captured with the group
//   vld_o/q_o/sat_o  quantized result, saturation flag
module requant_rs
  import aix_quant_pkg::*;
#(
  parameter int WS = WS_DEF,
  parameter int WQ = WQ_DEF
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 in_vld,
  input  logic signed [WS-1:0] in_dat,
  input  logic                 in_ovf,
  input  logic [4:0]           in_shift,
  input  logic                 in_relu,
  output logic                 vld_o,
  output logic [WQ-1:0]        q_o,
  output logic                 sat_o
);

  localparam logic signed [WS:0] HI = (WS+1)'(SAT_MAX);
  localparam logic signed [WS:0] LO = (WS+1)'(SAT_MIN);

  // One extra bit so adding the rounding constant to a near-max value cannot wrap.
  logic signed [WS:0] ext;
  logic signed [WS:0] rnd;
  logic signed [WS:0] rsum;
  logic signed [WS:0] shifted;

  always_comb begin
    ext     = {in_dat[WS-1], in_dat};
    rnd     = (in_shift != 5'd0) ? ((WS+1)'(1) << (in_shift - 5'd1)) : '0;
    rsum    = ext + rnd;
    shifted = rsum >>> in_shift;
  end

  logic               s1_vld;
  logic signed [WS:0] s1_val;
  logic               s1_ovf;
  logic               s1_relu;

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      s1_vld  <= 1'b0;
      s1_val  <= '0;
      s1_ovf  <= 1'b0;
      s1_relu <= 1'b0;
    end else begin
      s1_vld <= in_vld;
      if (in_vld) begin
        s1_val  <= shifted;
        s1_ovf  <= in_ovf;
        s1_relu <= in_relu;
      end
    end
  end

  logic [WQ-1:0] q_nxt;
  logic          sat_nxt;

  // ReLU clamp wins over negative saturation and does not itself flag sat_o.
  always_comb begin
    q_nxt   = s1_val[WQ-1:0];
    sat_nxt = s1_ovf;
    if (s1_relu && s1_val[WS]) begin
      q_nxt = '0;
    end else if (s1_val > HI) begin
      q_nxt   = SAT_MAX;
      sat_nxt = 1'b1;
    end else if (s1_val < LO) begin
      q_nxt   = SAT_MIN;
      sat_nxt = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      vld_o <= 1'b0;
      q_o   <= '0;
      sat_o <= 1'b0;
    end else begin
      vld_o <= s1_vld;
      if (s1_vld) begin
        q_o   <= q_nxt;
        sat_o <= sat_nxt;
      end
    end
  end

endmodule

// File: rtl/psum_requant.sv
// Accumulates MAC partial sums over cfg_tiles tiles plus bias, then rounds/shifts/saturates to WQ bits.
// Latency: vld_o rises 3 cycles after the final vld_i of a group.
// Backpressure: none; every vld_i is consumed, groups may run back to back.
//
// Optional feature macro: PSUM_RELU_EN (registers cfg_relu, clamps negative results to 0).
// Ports:
//   clk, rstn                                  clock, async active-low reset
//   cfg_we, cfg_tiles, cfg_shift, cfg_bias, cfg_relu   config write (IDLE only)
//   vld_i, acc_i, clr_i                        partial-sum input, group abort
//   busy_o, cfg_err_o                          group in progress, rejected config pulse
//   vld_o, q_o, sat_o                          quantized result
module psum_requant
  import aix_quant_pkg::*;
#(
  parameter int WA = WA_DEF,
  parameter int WS = WS_DEF,
  parameter int WB = WB_DEF,
  parameter int WT = WT_DEF,
  parameter int WQ = WQ_DEF
) (
  input  logic          clk,
  input  logic          rstn,
  input  logic          cfg_we,
  input  logic [WT-1:0] cfg_tiles,
  input  logic [4:0]    cfg_shift,
  input  logic [WB-1:0] cfg_bias,
  input  logic          cfg_relu,
  input  logic          vld_i,
  input  logic [WA-1:0] acc_i,
  input  logic          clr_i,
  output logic          busy_o,
  output logic          cfg_err_o,
  output logic          vld_o,
  output logic [WQ-1:0] q_o,
  output logic          sat_o
);

  // Saturating signed add; MSB of the result is the overflow flag.
  function automatic logic [WS:0] sat_add(input logic signed [WS-1:0] a,
                                          input logic signed [WS-1:0] b);
    logic signed [WS-1:0] s;
    logic                 o;
    s = a + b;
    o = (a[WS-1] == b[WS-1]) && (s[WS-1] != a[WS-1]);
    if (o) s = a[WS-1] ? {1'b1, {(WS-1){1'b0}}} : {1'b0, {(WS-1){1'b1}}};
    return {o, s};
  endfunction

  logic [WT-1:0]        tiles_r;
  logic [4:0]           shift_r;
  logic [WB-1:0]        bias_r;
  logic                 relu_r;

  state_t               state;
  logic [WT-1:0]        cnt;
  logic signed [WS-1:0] psum;
  logic                 ovf_r;

  logic                 fin_vld;
  logic signed [WS-1:0] fin_dat;
  logic                 fin_ovf;
  logic [4:0]           fin_shift;
  logic                 fin_relu;

  logic [WT-1:0]        tiles_eff;
  logic signed [WS-1:0] acc_x;
  logic signed [WS-1:0] bias_x;
  logic signed [WS-1:0] add_a;
  logic signed [WS-1:0] add_b;
  logic signed [WS-1:0] add_sum;
  logic                 add_ovf;
  logic                 last;
  logic                 ovf_any;

  // One shared adder: the first tile of a group adds bias, later tiles add to psum.
  always_comb begin
    tiles_eff = (tiles_r == '0) ? WT'(1) : tiles_r;
    acc_x     = sext(WS'(acc_i), WA);
    bias_x    = sext(WS'(bias_r), WB);
    add_a     = (state == ST_IDLE) ? acc_x : psum;
    add_b     = (state == ST_IDLE) ? bias_x : acc_x;
    {add_ovf, add_sum} = sat_add(add_a, add_b);
    last      = (state == ST_IDLE) ? (tiles_eff == WT'(1))
                                   : (cnt == tiles_eff - WT'(1));
    ovf_any   = add_ovf | ((state == ST_ACCUM) & ovf_r);
  end

  assign busy_o = (state == ST_ACCUM);

`ifdef PSUM_RELU_EN
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn)                               relu_r <= 1'b0;
    else if (cfg_we && (state == ST_IDLE))   relu_r <= cfg_relu;
  end
`else
  logic unused_relu;
  assign unused_relu = cfg_relu;
  assign relu_r      = 1'b0;
`endif

  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      tiles_r   <= '0;
      shift_r   <= '0;
      bias_r    <= '0;
      cfg_err_o <= 1'b0;
      state     <= ST_IDLE;
      cnt       <= '0;
      psum      <= '0;
      ovf_r     <= 1'b0;
      fin_vld   <= 1'b0;
      fin_dat   <= '0;
      fin_ovf   <= 1'b0;
      fin_shift <= '0;
      fin_relu  <= 1'b0;
    end else begin
      cfg_err_o <= cfg_we && (state == ST_ACCUM);
      // Config lands at the edge, so a vld_i in the same cycle still sees the old values.
      if (cfg_we && (state == ST_IDLE)) begin
        tiles_r <= cfg_tiles;
        shift_r <= cfg_shift;
        bias_r  <= cfg_bias;
      end

      fin_vld <= 1'b0;
      if (clr_i) begin
        state <= ST_IDLE;
        cnt   <= '0;
        psum  <= '0;
        ovf_r <= 1'b0;
      end else if (vld_i) begin
        if (last) begin
          // Shift/ReLU travel with the data so a config write right after finalize is safe.
          fin_vld   <= 1'b1;
          fin_dat   <= add_sum;
          fin_ovf   <= ovf_any;
          fin_shift <= shift_r;
          fin_relu  <= relu_r;
          state     <= ST_IDLE;
          cnt       <= '0;
          psum      <= '0;
          ovf_r     <= 1'b0;
        end else begin
          psum  <= add_sum;
          ovf_r <= ovf_any;
          cnt   <= cnt + WT'(1);
          state <= ST_ACCUM;
        end
      end
    end
  end

  requant_rs #(.WS(WS), .WQ(WQ)) u_rs (
    .clk      (clk),
    .rstn     (rstn),
    .in_vld   (fin_vld),
    .in_dat   (fin_dat),
    .in_ovf   (fin_ovf),
    .in_shift (fin_shift),
    .in_relu  (fin_relu),
    .vld_o    (vld_o),
    .q_o      (q_o),
    .sat_o    (sat_o)
  );

endmodule

// File: tb/tb_psum_requant.sv
// Directed-vector bench for psum_requant.
// Latency: n/a.
// Backpressure: n/a.
module tb_psum_requant;

  logic        clk = 1'b0;
  logic        rstn;
  logic        cfg_we;
  logic [7:0]  cfg_tiles;
  logic [4:0]  cfg_shift;
  logic [15:0] cfg_bias;
  logic        cfg_relu;
  logic        vld_i;
  logic [25:0] acc_i;
  logic        clr_i;
  logic        busy_o;
  logic        cfg_err_o;
  logic        vld_o;
  logic [7:0]  q_o;
  logic        sat_o;

  int total = 0;
  int bad   = 0;
  int npulse = 0;

  psum_requant dut (
    .clk       (clk),
    .rstn      (rstn),
    .cfg_we    (cfg_we),
    .cfg_tiles (cfg_tiles),
    .cfg_shift (cfg_shift),
    .cfg_bias  (cfg_bias),
    .cfg_relu  (cfg_relu),
    .vld_i     (vld_i),
    .acc_i     (acc_i),
    .clr_i     (clr_i),
    .busy_o    (busy_o),
    .cfg_err_o (cfg_err_o),
    .vld_o     (vld_o),
    .q_o       (q_o),
    .sat_o     (sat_o)
  );

  always #5 clk = ~clk;

  always @(negedge clk) if (vld_o) npulse++;

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic set_cfg(input int t, input int s, input int b, input bit r);
    cfg_we    = 1'b1;
    cfg_tiles = 8'(t);
    cfg_shift = 5'(s);
    cfg_bias  = 16'(b);
    cfg_relu  = r;
    cyc();
    cfg_we    = 1'b0;
  endtask

  task automatic send(input int a);
    vld_i = 1'b1;
    acc_i = 26'(a);
    cyc();
    vld_i = 1'b0;
    acc_i = '0;
  endtask

  // Waits (bounded) for the next vld_o; lat counts cycles from the final vld_i cycle.
  task automatic wait_out(output bit got, output logic [7:0] q, output logic s, output int lat);
    got = 1'b0; q = '0; s = 1'b0; lat = 0;
    for (int i = 1; i <= 10; i++) begin
      cyc();
      if (vld_o) begin
        got = 1'b1; q = q_o; s = sat_o; lat = i + 1;
        break;
      end
    end
  endtask

  task automatic test_reset();
    rstn = 1'b0; cfg_we = 0; cfg_tiles = 0; cfg_shift = 0; cfg_bias = 0; cfg_relu = 0;
    vld_i = 0; acc_i = 0; clr_i = 0;
    repeat (3) cyc();
    total++;
    if ({busy_o, cfg_err_o, vld_o, q_o, sat_o} !== 12'h000) begin
      bad++;
      $display("FAIL reset_outputs got=%h exp=000", {busy_o, cfg_err_o, vld_o, q_o, sat_o});
    end
    rstn = 1'b1;
    cyc();
    total++;
    if ({busy_o, vld_o} !== 2'b00) begin
      bad++; $display("FAIL reset_release got=%b exp=00", {busy_o, vld_o});
    end
  endtask

  task automatic test_basic();
    bit got; logic [7:0] q; logic s; int lat;
    set_cfg(3, 2, 10, 0);
    send(100);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL basic_busy got=%b exp=1", busy_o); end
    send(200);
    send(-50);
    wait_out(got, q, s, lat);
    total++;
    if (!got || lat != 3) begin bad++; $display("FAIL basic_latency got=%0d exp=3 (seen=%0d)", lat, got); end
    total++;
    if (q !== 8'd65 || s !== 1'b0) begin
      bad++; $display("FAIL basic_value got=%0d/%b exp=65/0", $signed(q), s);
    end
    cyc();
    total++;
    if (vld_o !== 1'b0) begin bad++; $display("FAIL basic_pulse got=%b exp=0", vld_o); end
  endtask

  task automatic test_saturate();
    // tiles, shift, bias, acc, expected q, expected sat
    int tv[7][6] = '{
      '{1, 0,   0,   300,  127, 1},
      '{1, 3,   0, -1000, -125, 0},
      '{0, 0,   5,   -20,  -15, 0},
      '{1, 0,   0, -1000, -128, 1},
      '{1, 1,   0,     5,    3, 0},
      '{1, 1,   0,    -5,   -2, 0},
      '{1, 0, -10,     3,   -7, 0}
    };
    bit got; logic [7:0] q; logic s; int lat;
    logic [7:0] eq;
    for (int i = 0; i < 7; i++) begin
      set_cfg(tv[i][0], tv[i][1], tv[i][2], 0);
      send(tv[i][3]);
      total++;
      if (busy_o !== 1'b0) begin bad++; $display("FAIL sat_busy[%0d] got=%b exp=0", i, busy_o); end
      wait_out(got, q, s, lat);
      eq = 8'(tv[i][4]);
      total++;
      if (!got || q !== eq || s !== 1'(tv[i][5])) begin
        bad++;
        $display("FAIL sat_vec[%0d] got=%0d/%b seen=%0d exp=%0d/%0d", i, $signed(q), s, got, tv[i][4], tv[i][5]);
      end
    end
  endtask

  task automatic test_overflow();
    bit got; logic [7:0] q; logic s; int lat;
    // 65 max tiles overflow the accumulator; the last tile pulls it back in range.
    set_cfg(66, 31, 0, 0);
    for (int i = 0; i < 65; i++) send(33554431);
    send(-33554432);
    wait_out(got, q, s, lat);
    total++;
    if (!got || q !== 8'd1 || s !== 1'b1) begin
      bad++; $display("FAIL overflow_sticky got=%0d/%b seen=%0d exp=1/1", $signed(q), s, got);
    end
  endtask

  task automatic test_back_to_back();
    int         vals[8] = '{10, 20, -5, -6, 100, 27, 100, 28};
    logic [7:0] eq[4]   = '{8'd30, 8'hF5, 8'd127, 8'd127};
    logic       es[4]   = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic       ev;
    set_cfg(2, 0, 0, 0);
    for (int i = 0; i <= 12; i++) begin
      vld_i = (i < 8);
      acc_i = (i < 8) ? 26'(vals[i]) : '0;
      ev = (i >= 4) && (i <= 10) && (i % 2 == 0);
      total++;
      if (vld_o !== ev) begin bad++; $display("FAIL b2b_vld[%0d] got=%b exp=%b", i, vld_o, ev); end
      if (ev) begin
        total++;
        if (q_o !== eq[(i-4)/2] || sat_o !== es[(i-4)/2]) begin
          bad++;
          $display("FAIL b2b_val[%0d] got=%0d/%b exp=%0d/%b", i, $signed(q_o), sat_o,
                   $signed(eq[(i-4)/2]), es[(i-4)/2]);
        end
      end
      cyc();
    end
    vld_i = 1'b0;
  endtask

  task automatic test_cfg_err();
    bit got; logic [7:0] q; logic s; int lat;
    set_cfg(2, 0, 0, 0);
    total++;
    if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL cfgerr_idle got=%b exp=0", cfg_err_o); end
    send(5);
    cfg_we = 1'b1; cfg_tiles = 8'd1; cfg_shift = 5'd4; cfg_bias = 16'd100;
    vld_i = 1'b1; acc_i = 26'd7;
    cyc();
    cfg_we = 1'b0; vld_i = 1'b0;
    total++;
    if (cfg_err_o !== 1'b1) begin bad++; $display("FAIL cfgerr_pulse got=%b exp=1", cfg_err_o); end
    cyc();
    total++;
    if (cfg_err_o !== 1'b0) begin bad++; $display("FAIL cfgerr_width got=%b exp=0", cfg_err_o); end
    wait_out(got, q, s, lat);
    total++;
    if (!got || q !== 8'd12 || s !== 1'b0) begin
      bad++; $display("FAIL cfgerr_oldcfg got=%0d/%b seen=%0d exp=12/0", $signed(q), s, got);
    end
    send(1);
    total++;
    if (busy_o !== 1'b1) begin bad++; $display("FAIL cfgerr_tiles got=%b exp=1", busy_o); end
    send(2);
    wait_out(got, q, s, lat);
    total++;
    if (!got || q !== 8'd3) begin bad++; $display("FAIL cfgerr_next got=%0d seen=%0d exp=3", $signed(q), got); end
  endtask

  task automatic test_clear();
    bit got; logic [7:0] q; logic s; int lat; int n0;
    set_cfg(3, 0, 0, 0);
    n0 = npulse;
    send(50);
    clr_i = 1'b1; vld_i = 1'b1; acc_i = 26'd99;
    cyc();
    clr_i = 1'b0; vld_i = 1'b0;
    total++;
    if (busy_o !== 1'b0) begin bad++; $display("FAIL clr_busy got=%b exp=0", busy_o); end
    repeat (5) cyc();
    total++;
    if (npulse != n0) begin bad++; $display("FAIL clr_nooutput got=%0d exp=%0d", npulse, n0); end
    send(1); send(2); send(3);
    wait_out(got, q, s, lat);
    total++;
    if (!got || q !== 8'd6 || s !== 1'b0) begin
      bad++; $display("FAIL clr_clean got=%0d/%b seen=%0d exp=6/0", $signed(q), s, got);
    end
    // A clear right after finalize must not kill the result already in flight.
    set_cfg(1, 0, 0, 0);
    send(9);
    clr_i = 1'b1;
    cyc();
    clr_i = 1'b0;
    wait_out(got, q, s, lat);
    total++;
    if (!got || q !== 8'd9) begin bad++; $display("FAIL clr_inflight got=%0d seen=%0d exp=9", $signed(q), got); end
  endtask

  task automatic test_relu();
    bit got; logic [7:0] q; logic s; int lat;
`ifdef PSUM_RELU_EN
    int tv[3][3] = '{'{-40, 0, 0}, '{50, 50, 0}, '{-300, 0, 0}};
`else
    int tv[3][3] = '{'{-40, -40, 0}, '{50, 50, 0}, '{-300, -128, 1}};
`endif
    logic [7:0] eq;
    set_cfg(1, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      send(tv[i][0]);
      wait_out(got, q, s, lat);
      eq = 8'(tv[i][1]);
      total++;
      if (!got || q !== eq || s !== 1'(tv[i][2])) begin
        bad++;
        $display("FAIL relu[%0d] got=%0d/%b seen=%0d exp=%0d/%0d", i, $signed(q), s, got, tv[i][1], tv[i][2]);
      end
    end
  endtask

  task automatic test_reset_mid();
    bit got; logic [7:0] q; logic s; int lat; int n0;
    set_cfg(1, 0, 0, 0);
    send(50);
    n0 = npulse;
    rstn = 1'b0;
    #1;
    total++;
    if (q_o !== 8'd0 || vld_o !== 1'b0) begin
      bad++; $display("FAIL rst_async got=%0d/%b exp=0/0", $signed(q_o), vld_o);
    end
    cyc();
    rstn = 1'b1;
    repeat (5) cyc();
    total++;
    if (npulse != n0) begin bad++; $display("FAIL rst_inflight got=%0d exp=%0d", npulse, n0); end
    // Config was wiped: tiles=0 acts as 1, shift and bias are 0.
    send(7);
    wait_out(got, q, s, lat);
    total++;
    if (!got || q !== 8'd7 || s !== 1'b0) begin
      bad++; $display("FAIL rst_cfgdefault got=%0d/%b seen=%0d exp=7/0", $signed(q), s, got);
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_saturate();
    test_overflow();
    test_back_to_back();
    test_cfg_err();
    test_clear();
    test_relu();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
